// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width and Gray-code helpers shared by both FIFO domain controllers
package fifo_pkg;
  localparam int MAX_W = 32;
  function automatic int ptr_w(input int addr_size);
    return addr_size + 1;
  endfunction
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop clock-domain-crossing synchroniser, no logic between stages
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q1;
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read-domain pointer/empty logic with a 2-entry FWFT output stage
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 4,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE:0]   wq_gray,
  output logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 empty
);
  localparam int PTR_W = ptr_w(ADDR_SIZE);
  logic [PTR_W-1:0] rbin, rbin_next, rgray_next, rq2_wptr;
  logic [DATA_SIZE-1:0] tail;
  logic [1:0] occ, base;
  logic [2:0] demand;
  logic inflight, pop;
  sync_2ff #(.W(PTR_W)) u_sync (.clk(rd_clk), .rst(rst), .d(wq_gray), .q(rq2_wptr));
  assign out_valid  = occ != 2'd0;
  assign pop        = out_valid && out_ready;
  // words held or arriving after this cycle's pop; a new read only fits if at most one remains
  assign demand     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en      = !empty && demand <= 3'd1;
  assign rd_addr    = rbin[ADDR_SIZE-1:0];
  assign rbin_next  = rbin + PTR_W'(rd_en);
  assign rgray_next = PTR_W'(bin2gray(MAX_W'(rbin_next)));
  assign base       = occ - {1'b0, pop};
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      inflight    <= 1'b0;
      occ         <= 2'd0;
      out_data    <= '0;
      tail        <= '0;
    end else begin
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      empty       <= rgray_next == rq2_wptr;
      inflight    <= rd_en;
      occ         <= demand[1:0];
      out_data    <= (inflight && base == 2'd0) ? mem_rdata : pop ? tail : out_data;
      tail        <= (inflight && base == 2'd1) ? mem_rdata : tail;
    end
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller of the N-bit asynchronous FIFO, counterpart to the write-side logic.
- Synchronises the write pointer into rd_clk and maintains the binary/Gray read pointer.
- Generates the registered empty flag and drives rd_addr/rd_en into fifomem.
- Presents data through a 2-entry first-word-fall-through output stage with valid/ready handshake, sustaining one word per cycle.

Parameters:
- DATA_SIZE, 4, word width.
- ADDR_SIZE, 4, memory address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.

Ports:
- rd_clk  in  1  read-domain clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rd_clk.
- wq_gray  in  ADDR_SIZE+1  write pointer (Gray) from write domain, asynchronous to rd_clk.
- rd_ptr_gray  out  ADDR_SIZE+1  registered read pointer (Gray), to write domain.
- rd_addr  out  ADDR_SIZE  memory read address = rbin[ADDR_SIZE-1:0].
- rd_en  out  1  memory read strobe; one word popped from FIFO storage.
- mem_rdata  in  DATA_SIZE  fifomem rd_data, valid the cycle after rd_en.
- out_data  out  DATA_SIZE  head-of-stage data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts; pop = out_valid && out_ready.
- empty  out  1  registered FIFO-storage empty flag.

Behaviour:
- Reset values:
  - rbin = 0, rd_ptr_gray = 0.
  - Synchroniser flops rq1/rq2 = 0.
  - empty = 1, out_valid = 0, out_data = 0.
  - inflight = 0, occ = 0.
  - rd_en = 0 (combinational but forced low while empty=1).
- Synchroniser:
  - wq_gray passes through two rd_clk flops to give rq2_wptr.
  - Latency 2 cycles; no logic between the flops.
- Pointer:
  - rbin_next = rbin + rd_en; rgray_next = (rbin_next>>1) ^ rbin_next.
  - Both registered; natural wrap at 2**(ADDR_SIZE+1).
- Empty:
  - empty <= (rgray_next == rq2_wptr), using the full ADDR_SIZE+1-bit compare.
  - Deasserts no earlier than 2 rd_clk cycles after wq_gray changes.
  - Asserts in the cycle after the last word's rd_en.
- Output stage (2-entry skid, occ 0..2, inflight flag):
  - rd_en = !empty && (occ + inflight - pop) <= 1.
  - inflight <= rd_en.
  - When inflight=1, mem_rdata is written into the stage tail that cycle.
  - Head of stage drives out_data; out_valid = (occ != 0).
  - occ_next = occ + inflight - pop.
  - Simultaneous capture and pop: head advances and tail is written in the same cycle; occ unchanged.
  - Entry order strictly FIFO.
- Throughput and latency:
  - Steady state occ=1, inflight=1, out_ready=1 gives one word per cycle.
  - First word: rd_en in cycle N (first cycle empty=0), out_valid in N+2.
- Stall:
  - With out_ready=0, at most 2 words are held in the stage plus 0 in flight.
  - rd_en stays low; no data is lost or duplicated.
- Boundaries:
  - occ never exceeds 2.
  - rd_en never asserts while empty=1.
  - Read pointer wraps through all 2**(ADDR_SIZE+1) values without a glitch in empty.
- Reset mid-operation:
  - All state returns to reset values next edge.
  - Any in-flight word is discarded.
  - Reset must be applied to the write domain concurrently; fifomem contents are don't-care.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions.
  - Pointer width constant PTR_W = ADDR_SIZE+1 (as a parameterised function or localparam pattern).
- Sub-module sync_2ff:
  - Parameterised-width 2-flop synchroniser with synchronous rst.
  - Shared with the write-side controller for rq2_rptr.

Test Plan:
- Reset then idle, wq_gray=0 -> empty=1, out_valid=0, rd_en=0, rd_ptr_gray=0 for 20 cycles.
- Write side advances wq_gray to gray(3)=5'b00010 at cycle 0, out_ready=1:
  - empty falls at cycle 3; rd_en pulses at rd_addr 0,1,2.
  - out_data 0xA,0xB,0xC on consecutive cycles; empty=1 again after third rd_en; rd_ptr_gray ends 5'b00010.
- out_ready=0 with 8 words available -> exactly 2 rd_en pulses, occ=2; release out_ready -> remaining 6 words stream one per cycle in order.
- out_ready toggles 1010 pattern over 16 words -> no drop, no duplicate; data sequence matches scoreboard.
- Wrap: pre-fill/drain 40 words with ADDR_SIZE=4:
  - rbin passes 31->0; rd_ptr_gray returns to 0 after 32 reads.
  - empty never falsely deasserts.
- rst asserted with occ=2 and inflight=1 -> next cycle out_valid=0, empty=1, rbin=0; no stale word appears after reset release.
